// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: state encoding, width defaults and
// instruction field helpers used by decode.
package fetch_unit_pkg;

    localparam int ADDR_W_DEF  = 6;
    localparam int INSTR_W_DEF = 16;
    localparam int PC_MAX      = 63;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_LATCH = 3'd2;
    localparam logic [2:0] ST_VALID = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    typedef struct packed {
        logic [1:0] iclass;
        logic [4:0] opcode;
        logic [8:0] operand;
    } instr_fields_t;

    function automatic logic [1:0] instr_class(input logic [15:0] instr);
        return instr[15:14];
    endfunction

    function automatic logic [4:0] instr_opcode(input logic [15:0] instr);
        return instr[13:9];
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, drives the registered instruction-memory read port
// and presents each captured word to decode over a valid/ready handshake.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_enable,
    input  logic               run,
    input  logic [ADDR_W-1:0]  prog_len,
    output logic [ADDR_W-1:0]  read_address,
    input  logic [INSTR_W-1:0] instruction_in,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               halted,
    output logic               fault
);

    localparam logic [ADDR_W-1:0] PC_LAST = ADDR_W'(PC_MAX);
    localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

    logic [2:0]         state;
    logic [ADDR_W-1:0]  pc_p0;
    logic [INSTR_W-1:0] instr_p1;
    logic [ADDR_W-1:0]  instr_pc_p1;
    logic               vld_p1;
    logic               fault_p0;
    logic               redir_ok;
    logic               last_pc;

    // prog_len is compared live so a change while running applies immediately
    assign redir_ok = (redirect_target < prog_len);
    assign last_pc  = (pc_p0 == prog_len - ONE) || (pc_p0 == PC_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            pc_p0       <= '0;
            instr_p1    <= '0;
            instr_pc_p1 <= '0;
            vld_p1      <= 1'b0;
            fault_p0    <= 1'b0;
        end else if (clk_enable) begin
            case (state)
                ST_IDLE: begin
                    pc_p0 <= '0;
                    if (run) begin
                        state <= (prog_len == '0) ? ST_HALT : ST_ISSUE;
                    end
                end
                ST_ISSUE, ST_LATCH, ST_VALID: begin
                    // redirect outranks both the capture and the handshake
                    if (redirect) begin
                        vld_p1 <= 1'b0;
                        if (redir_ok) begin
                            pc_p0 <= redirect_target;
                            state <= ST_ISSUE;
                        end else begin
                            fault_p0 <= 1'b1;
                            state    <= ST_HALT;
                        end
                    end else if (state == ST_ISSUE) begin
                        state <= ST_LATCH;
                    end else if (state == ST_LATCH) begin
                        // stage p1: memory word for pc_p0 is on instruction_in now
                        instr_p1    <= instruction_in;
                        instr_pc_p1 <= pc_p0;
                        vld_p1      <= 1'b1;
                        state       <= ST_VALID;
                    end else if (instr_ready) begin
                        vld_p1 <= 1'b0;
                        if (last_pc) begin
                            state <= ST_HALT;
                        end else begin
                            pc_p0 <= pc_p0 + ONE;
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_HALT: begin
                    if (run && (prog_len != '0)) begin
                        pc_p0    <= '0;
                        fault_p0 <= 1'b0;
                        state    <= ST_ISSUE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign read_address = pc_p0;
    assign instr_out    = instr_p1;
    assign instr_pc     = instr_pc_p1;
    assign instr_valid  = vld_p1;
    assign halted       = (state == ST_HALT);
    assign fault        = fault_p0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model of the fetch sequence.
module tb_fetch_unit;

    localparam int AW = 6;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          clk_enable;
    logic          run;
    logic [AW-1:0] prog_len;
    logic [AW-1:0] read_address;
    logic [IW-1:0] instruction_in;
    logic [IW-1:0] instr_out;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic          redirect;
    logic [AW-1:0] redirect_target;
    logic          halted;
    logic          fault;

    always #5 clk = ~clk;

    logic [IW-1:0] mem [64];
    logic [IW-1:0] mem_q;

    always @(posedge clk) if (clk_enable) mem_q <= mem[read_address];
    assign instruction_in = mem_q;

    fetch_unit #(.ADDR_W(AW), .INSTR_W(IW)) dut (
        .clk            (clk),
        .reset          (reset),
        .clk_enable     (clk_enable),
        .run            (run),
        .prog_len       (prog_len),
        .read_address   (read_address),
        .instruction_in (instruction_in),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .halted         (halted),
        .fault          (fault)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc_n = 0;

    typedef struct {
        int cyc;
        int pc;
        int word;
    } hs_t;
    hs_t log_q[$];

    // Model: architectural PC plus a count of enabled edges until the word shows up.
    bit m_running, m_halted, m_fault, m_valid;
    int m_pc, m_cnt;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic model_reset();
        m_running = 0; m_halted = 0; m_fault = 0; m_valid = 0;
        m_pc = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        int len;
        len = int'(prog_len);
        if (!m_running) begin
            if (run) begin
                if (len == 0) m_halted = 1;
                else begin
                    m_pc = 0; m_halted = 0; m_fault = 0; m_valid = 0;
                    m_cnt = 2; m_running = 1;
                end
            end
        end else if (redirect) begin
            m_valid = 0;
            if (int'(redirect_target) < len) begin
                m_pc = int'(redirect_target); m_cnt = 2;
            end else begin
                m_fault = 1; m_halted = 1; m_running = 0;
            end
        end else if (m_valid) begin
            if (instr_ready) begin
                m_valid = 0;
                if (m_pc == len - 1 || m_pc == 63) begin
                    m_halted = 1; m_running = 0;
                end else begin
                    m_pc = m_pc + 1; m_cnt = 2;
                end
            end
        end else begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) m_valid = 1;
        end
    endtask

    task automatic check_outputs();
        chk("read_address", read_address, m_pc);
        chk("instr_valid", instr_valid, m_valid);
        chk("halted", halted, m_halted);
        chk("fault", fault, m_fault);
        if (m_valid) begin
            chk("instr_pc", instr_pc, m_pc);
            chk("instr_out", instr_out, mem[m_pc]);
        end
    endtask

    task automatic cycle();
        if (reset && clk_enable && instr_valid && instr_ready && !redirect)
            log_q.push_back('{cyc_n, int'(instr_pc), int'(instr_out)});
        @(posedge clk);
        if (reset && clk_enable) model_step();
        cyc_n++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (!instr_valid && n < max) begin
            cycle();
            n++;
        end
        if (!instr_valid) chk("wait_valid_timeout", 0, 1);
    endtask

    task automatic wait_pc(input int pc, input int max);
        int n;
        n = 0;
        while (!(instr_valid && int'(instr_pc) == pc) && n < max) begin
            cycle();
            n++;
        end
        if (!(instr_valid && int'(instr_pc) == pc)) chk("wait_pc_timeout", 0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b0; run = 1'b0; redirect = 1'b0; redirect_target = '0;
        instr_ready = 1'b0; clk_enable = 1'b1;
        model_reset();
        @(negedge clk);
        check_outputs();
        reset = 1'b1;
        log_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, start;
        logic [IW-1:0] held;
        for (int i = 0; i < 64; i++) mem[i] = IW'($urandom);
        prog_len = '0;
        do_reset();

        // Linear run of three words
        mem[0] = 16'hA11A; mem[1] = 16'hB22B; mem[2] = 16'hC33C;
        prog_len = 6'd3; instr_ready = 1'b1;
        start = cyc_n;
        run = 1'b1; cycle(); run = 1'b0;
        repeat (10) cycle();
        chk("lin_count", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("lin_latency", log_q[0].cyc - start, 3);
            chk("lin_pc0", log_q[0].pc, 0);   chk("lin_w0", log_q[0].word, 16'hA11A);
            chk("lin_pc1", log_q[1].pc, 1);   chk("lin_w1", log_q[1].word, 16'hB22B);
            chk("lin_pc2", log_q[2].pc, 2);   chk("lin_w2", log_q[2].word, 16'hC33C);
            chk("lin_space", log_q[2].cyc - log_q[1].cyc, 3);
        end
        chk("lin_halted", halted, 1);
        chk("lin_fault", fault, 0);

        // Backpressure on word @1
        prog_len = 6'd8; instr_ready = 1'b0;
        run = 1'b1; cycle(); run = 1'b0;
        wait_valid(10, n);
        instr_ready = 1'b1; cycle(); instr_ready = 1'b0;
        wait_valid(10, n);
        held = instr_out;
        repeat (5) begin
            cycle();
            chk("bp_pc_hold", instr_pc, 1);
            chk("bp_raddr", read_address, 1);
            chk("bp_word_hold", instr_out, held);
        end
        instr_ready = 1'b1; cycle(); instr_ready = 1'b0;
        wait_valid(10, k);
        chk("bp_latency", k + 1, 3);
        chk("bp_next_pc", instr_pc, 2);

        // Redirect during LATCH of PC 4
        instr_ready = 1'b1;
        wait_pc(3, 20);
        cycle();
        cycle();
        chk("rd_in_latch", read_address, 4);
        redirect = 1'b1; redirect_target = 6'd0;
        cycle();
        redirect = 1'b0; instr_ready = 1'b0;
        wait_valid(10, k);
        chk("rd_latch_pc", instr_pc, 0);
        chk("rd_latch_lat", k + 1, 3);

        // Redirect coincident with accept
        instr_ready = 1'b1; redirect = 1'b1; redirect_target = 6'd5;
        cycle();
        redirect = 1'b0; instr_ready = 1'b0;
        wait_valid(10, k);
        chk("rd_coinc_pc", instr_pc, 5);
        chk("rd_coinc_lat", k + 1, 3);

        // Out-of-range redirect faults, run restarts cleanly
        redirect = 1'b1; redirect_target = 6'd9;
        cycle();
        redirect = 1'b0;
        chk("flt_halted", halted, 1);
        chk("flt_fault", fault, 1);
        chk("flt_valid", instr_valid, 0);
        run = 1'b1; cycle(); run = 1'b0;
        chk("flt_clear", fault, 0);
        chk("flt_unhalt", halted, 0);
        wait_valid(10, k);
        chk("flt_restart_pc", instr_pc, 0);

        // Empty program
        do_reset();
        prog_len = '0;
        run = 1'b1; cycle(); run = 1'b0;
        chk("len0_halted", halted, 1);
        repeat (4) cycle();
        chk("len0_novalid", instr_valid, 0);
        run = 1'b1; cycle(); run = 1'b0;
        chk("len0_stay", halted, 1);

        // Last-PC halt with prog_len 63
        do_reset();
        prog_len = 6'd63;
        run = 1'b1; cycle(); run = 1'b0;
        wait_valid(10, k);
        redirect = 1'b1; redirect_target = 6'd62;
        cycle();
        redirect = 1'b0;
        wait_valid(10, k);
        chk("len63_pc", instr_pc, 62);
        instr_ready = 1'b1; cycle(); instr_ready = 1'b0;
        chk("len63_halted", halted, 1);
        chk("len63_fault", fault, 0);

        // Alternating clock enable stretches the sequence
        do_reset();
        mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'h9ABC;
        prog_len = 6'd3; instr_ready = 1'b1;
        start = cyc_n;
        run = 1'b1; cycle(); run = 1'b0;
        for (int i = 0; i < 20; i++) begin
            clk_enable = (i % 2 == 1);
            cycle();
        end
        clk_enable = 1'b1;
        chk("en_count", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("en_latency", log_q[0].cyc - start, 6);
            chk("en_pc1", log_q[1].pc, 1);   chk("en_w1", log_q[1].word, 16'h5678);
            chk("en_pc2", log_q[2].pc, 2);   chk("en_w2", log_q[2].word, 16'h9ABC);
            chk("en_space", log_q[1].cyc - log_q[0].cyc, 6);
        end
        chk("en_halted", halted, 1);

        // Asynchronous reset while a word is held
        prog_len = 6'd8; instr_ready = 1'b1;
        run = 1'b1; cycle(); run = 1'b0;
        wait_pc(2, 20);
        instr_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr_out, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_raddr", read_address, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fault", fault, 0);
        model_reset();
        cycle();
        reset = 1'b1;
        repeat (3) cycle();

        // Random traffic
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            for (int i = 0; i < 64; i++) mem[i] = IW'($urandom);
            prog_len = (seg == 3) ? 6'd1 : (seg == 5) ? AW'($urandom_range(0, 63))
                                                      : AW'($urandom_range(2, 63));
            repeat (2500) begin
                run         = ($urandom_range(0, 9) == 0);
                clk_enable  = ($urandom_range(0, 3) != 0);
                instr_ready = ($urandom_range(0, 1) == 1);
                redirect    = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 3) == 0 || prog_len == '0)
                    redirect_target = AW'($urandom_range(0, 63));
                else
                    redirect_target = AW'($urandom_range(0, int'(prog_len) - 1));
                cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
